// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and alignment rule for the load/store unit
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_t;

  typedef enum logic {
    IDLE = 1'b0,
    RMW  = 1'b1
  } state_t;

  // Encoding 2'b11 is not a legal size and is reported as a fault.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - request, response and word-memory signals of the load/store unit
interface lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_misaligned;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wd;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_misaligned, mem_addr, mem_wd, mem_we
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_misaligned, mem_addr, mem_wd, mem_we
  );
endinterface

// File: rtl/lsu_lane.sv
// rtl/lsu_lane.sv - little-endian lane extract/extend for loads and lane merge for stores
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] ld_word_i,
  input  logic [1:0]  ld_off_i,
  input  logic [1:0]  ld_size_i,
  input  logic        ld_unsigned_i,
  output logic [31:0] ld_data_o,
  input  logic [31:0] st_old_i,
  input  logic [31:0] st_wdata_i,
  input  logic [1:0]  st_off_i,
  input  logic [1:0]  st_size_i,
  output logic [31:0] st_merged_o
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = ld_word_i[{ld_off_i, 3'b000} +: 8];
    half_v = ld_word_i[{ld_off_i[1], 4'b0000} +: 16];
    case (ld_size_i)
      SZ_BYTE: ld_data_o = {{24{~ld_unsigned_i & byte_v[7]}}, byte_v};
      SZ_HALF: ld_data_o = {{16{~ld_unsigned_i & half_v[15]}}, half_v};
      default: ld_data_o = ld_word_i;
    endcase
  end

  always_comb begin
    st_merged_o = st_old_i;
    case (st_size_i)
      SZ_BYTE: st_merged_o[{st_off_i, 3'b000} +: 8]     = st_wdata_i[7:0];
      SZ_HALF: st_merged_o[{st_off_i[1], 4'b0000} +: 16] = st_wdata_i[15:0];
      default: st_merged_o = st_wdata_i;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store front end for a word-only data memory
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic  clk,
  input logic  rst,
  lsu_if.slave bus
);
  if (DATA_W != 32) begin : g_bad_data_w
    $error("load_store_unit supports DATA_W = 32 only");
  end

  state_t            state_q, state_d;
  logic [DATA_W-1:0] old_q, old_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              valid_q, valid_d, mis_q, mis_d;
  logic [DATA_W-1:0] ld_data, merged;
  logic              accept, mis, sub_store;

  assign accept    = bus.req_valid && (state_q == IDLE);
  assign mis       = is_misaligned(bus.req_size, bus.req_addr[1:0]);
  assign sub_store = bus.req_we && !mis && (bus.req_size != SZ_WORD);

  lsu_lane u_lane (
    .ld_word_i     (bus.mem_rdata),
    .ld_off_i      (bus.req_addr[1:0]),
    .ld_size_i     (bus.req_size),
    .ld_unsigned_i (bus.req_unsigned),
    .ld_data_o     (ld_data),
    .st_old_i      (old_q),
    .st_wdata_i    (wdata_q),
    .st_off_i      (addr_q[1:0]),
    .st_size_i     (size_q),
    .st_merged_o   (merged)
  );

  always_comb begin
    state_d       = state_q;
    old_d         = old_q;
    wdata_d       = wdata_q;
    addr_d        = addr_q;
    size_d        = size_q;
    valid_d       = 1'b0;
    mis_d         = 1'b0;
    rdata_d       = '0;
    bus.req_ready = 1'b0;
    bus.mem_addr  = {bus.req_addr[ADDR_W-1:2], 2'b00};
    bus.mem_wd    = bus.req_wdata;
    bus.mem_we    = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (accept) begin
          mis_d   = mis;
          valid_d = !sub_store;
          if (mis) begin
            rdata_d = '0;
          end else if (!bus.req_we) begin
            rdata_d = ld_data;
          end else if (sub_store) begin
            // Memory writes whole words only: hold the old word and merge next cycle.
            old_d   = bus.mem_rdata;
            wdata_d = bus.req_wdata;
            addr_d  = bus.req_addr;
            size_d  = bus.req_size;
            state_d = RMW;
          end else begin
            bus.mem_we = 1'b1;
          end
        end
      end
      RMW: begin
        bus.mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
        bus.mem_wd   = merged;
        bus.mem_we   = 1'b1;
        valid_d      = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) bus.mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      old_q   <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      size_q  <= 2'b00;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      old_q   <= old_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.rsp_valid      = valid_q;
  assign bus.rsp_rdata      = rdata_q;
  assign bus.rsp_misaligned = mis_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed and randomized checks of load_store_unit
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] mem [0:63];
  logic        pre_we = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;
  assign bus.mem_rdata = mem[bus.mem_addr[7:2]];
  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wd;
  end

  logic [7:0] ref_mem [0:255];
  int total = 0;
  int bad = 0;

  task automatic poke(input int idx, input logic [31:0] d);
    pre_we = 1'b1; pre_idx = idx[5:0]; pre_data = d;
    @(posedge clk); #1 pre_we = 1'b0;
  endtask

  task automatic run_op(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic mis, output int lat,
                        output int we_cnt, output int we_cyc, output logic [31:0] we_data,
                        output int rdy_low);
    rd = '0; mis = 1'b0; lat = 0; we_cnt = 0; we_cyc = -1; we_data = '0; rdy_low = 0;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
    bus.req_unsigned = uns; bus.req_addr = a; bus.req_wdata = wd;
    #1;
    if (bus.mem_we) begin we_cnt++; we_cyc = 0; we_data = bus.mem_wd; end
    @(posedge clk); #1 bus.req_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (!bus.req_ready) rdy_low++;
      if (bus.mem_we) begin we_cnt++; we_cyc = k; we_data = bus.mem_wd; end
      if (bus.rsp_valid) begin lat = k; rd = bus.rsp_rdata; mis = bus.rsp_misaligned; break; end
    end
  endtask

  function automatic logic [31:0] ref_load(input int a, input logic [1:0] sz, input logic uns);
    int n;
    longint unsigned v;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    v = 0;
    for (int i = 0; i < n; i++) v = v | (longint'(ref_mem[a + i]) << (8 * i));
    if (!uns && ((v >> (8 * n - 1)) & 1) == 1) v = v | ~((64'd1 << (8 * n)) - 1);
    return v[31:0];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    poke(16, 32'h8899AABB);
    poke(17, 32'h11111111);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b10;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h44; bus.req_wdata = 32'hCAFEF00D;
    @(negedge clk);
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we: got %b want 0", bus.mem_we); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid); end
    total++; if (bus.rsp_rdata !== 32'h0) begin bad++; $display("FAIL rst_rsp_rdata: got %h want 0", bus.rsp_rdata); end
    total++; if (bus.rsp_misaligned !== 1'b0) begin bad++; $display("FAIL rst_mis: got %b want 0", bus.rsp_misaligned); end
    @(posedge clk); #1 rst = 1'b0; bus.req_valid = 1'b0;
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", bus.req_ready); end
    total++; if (mem[17] !== 32'h11111111) begin bad++; $display("FAIL rst_no_write: got %h want 11111111", mem[17]); end
  endtask

  task automatic test_loads();
    logic [31:0] rd, wdat; logic mis; int lat, wc, wcy, rl;
    logic [1:0]  szs [4] = '{2'd0, 2'd0, 2'd1, 2'd2};
    logic        us  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] as  [4] = '{32'h41, 32'h41, 32'h42, 32'h40};
    logic [31:0] exp [4] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h8899AABB};
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, szs[i], us[i], as[i], 32'h0, rd, mis, lat, wc, wcy, wdat, rl);
      total++; if (rd !== exp[i]) begin bad++; $display("FAIL load%0d_data: got %h want %h", i, rd, exp[i]); end
      total++; if (lat != 1 || mis !== 1'b0) begin bad++; $display("FAIL load%0d_rsp: got lat %0d mis %b want lat 1 mis 0", i, lat, mis); end
      total++; if (wc != 0) begin bad++; $display("FAIL load%0d_we: got %0d writes want 0", i, wc); end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  szs [3] = '{2'd0, 2'd1, 2'd2};
    logic [31:0] as  [3] = '{32'h41, 32'h42, 32'h40};
    logic [31:0] exp [3] = '{32'hFFFFFFAA, 32'hFFFF8899, 32'h8899AABB};
    int pulses = 0;
    bus.req_we = 1'b0; bus.req_unsigned = 1'b0; bus.req_wdata = '0;
    bus.req_valid = 1'b1; bus.req_size = szs[0]; bus.req_addr = as[0];
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i < 2) begin bus.req_size = szs[i + 1]; bus.req_addr = as[i + 1]; end
      else bus.req_valid = 1'b0;
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) pulses++;
      total++; if (bus.rsp_rdata !== exp[i]) begin bad++; $display("FAIL b2b%0d_data: got %h want %h", i, bus.rsp_rdata, exp[i]); end
    end
    total++; if (pulses != 3) begin bad++; $display("FAIL b2b_pulses: got %0d want 3", pulses); end
    @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL b2b_tail: got %b want 0", bus.rsp_valid); end
  endtask

  task automatic test_store_byte();
    logic [31:0] rd, wdat; logic mis; int lat, wc, wcy, rl;
    run_op(1'b1, 2'd0, 1'b0, 32'h43, 32'hABCDEF12, rd, mis, lat, wc, wcy, wdat, rl);
    total++; if (wc != 1 || wcy != 1) begin bad++; $display("FAIL sb_we: got %0d writes at cycle %0d want 1 at 1", wc, wcy); end
    total++; if (wdat !== 32'h1299AABB) begin bad++; $display("FAIL sb_wd: got %h want 1299aabb", wdat); end
    total++; if (rl != 1) begin bad++; $display("FAIL sb_ready: got %0d low cycles want 1", rl); end
    total++; if (lat != 2 || rd !== 32'h0) begin bad++; $display("FAIL sb_rsp: got lat %0d rdata %h want 2 0", lat, rd); end
    run_op(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, rd, mis, lat, wc, wcy, wdat, rl);
    total++; if (rd !== 32'h1299AABB) begin bad++; $display("FAIL sb_readback: got %h want 1299aabb", rd); end
  endtask

  task automatic test_store_word();
    logic [31:0] rd, wdat; logic mis; int lat, wc, wcy, rl;
    run_op(1'b1, 2'd2, 1'b0, 32'h44, 32'hDEADBEEF, rd, mis, lat, wc, wcy, wdat, rl);
    total++; if (wc != 1 || wcy != 0 || wdat !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_we: got %0d writes cycle %0d data %h want 1 0 deadbeef", wc, wcy, wdat); end
    total++; if (lat != 1 || rd !== 32'h0 || mis !== 1'b0) begin bad++; $display("FAIL sw_rsp: got lat %0d rdata %h mis %b want 1 0 0", lat, rd, mis); end
    total++; if (rl != 0) begin bad++; $display("FAIL sw_ready: got %0d low cycles want 0", rl); end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd, wdat; logic mis; int lat, wc, wcy, rl;
    logic        wes [3] = '{1'b0, 1'b1, 1'b0};
    logic [1:0]  szs [3] = '{2'd1, 2'd2, 2'd3};
    logic [31:0] as  [3] = '{32'h41, 32'h46, 32'h40};
    for (int i = 0; i < 3; i++) begin
      run_op(wes[i], szs[i], 1'b0, as[i], 32'h5A5A5A5A, rd, mis, lat, wc, wcy, wdat, rl);
      total++; if (mis !== 1'b1 || lat != 1) begin bad++; $display("FAIL mis%0d_flag: got mis %b lat %0d want 1 1", i, mis, lat); end
      total++; if (rd !== 32'h0 || wc != 0) begin bad++; $display("FAIL mis%0d_side: got rdata %h writes %0d want 0 0", i, rd, wc); end
    end
    total++; if (mem[17] !== 32'hDEADBEEF) begin bad++; $display("FAIL mis_mem: got %h want deadbeef", mem[17]); end
  endtask

  task automatic test_reset_rmw();
    int seen = 0;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h40; bus.req_wdata = 32'h55;
    @(posedge clk); #1 bus.req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL rrmw_we: got %b want 0", bus.mem_we); end
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) seen++;
      if (k == 0) begin
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rrmw_ready: got %b want 1", bus.req_ready); end
      end
    end
    total++; if (seen != 0) begin bad++; $display("FAIL rrmw_rsp: got %0d pulses want 0", seen); end
    total++; if (mem[16] !== 32'h1299AABB) begin bad++; $display("FAIL rrmw_mem: got %h want 1299aabb", mem[16]); end
  endtask

  task automatic test_random();
    logic [31:0] rd, wdat, w, wd, a, exp_rd; logic mis, we, uns, exp_mis; logic [1:0] sz;
    int lat, wc, wcy, rl, exp_lat, exp_wc;
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      poke(i, w);
      for (int b = 0; b < 4; b++) ref_mem[4 * i + b] = w[8 * b +: 8];
    end
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 3)); uns = 1'($urandom_range(0, 1));
      a = $urandom_range(0, 255); wd = $urandom;
      exp_mis = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
      exp_rd = '0; exp_lat = 1; exp_wc = 0;
      if (!exp_mis && !we) exp_rd = ref_load(int'(a), sz, uns);
      if (!exp_mis && we) begin
        exp_wc = 1;
        exp_lat = (sz == 2'd2) ? 1 : 2;
        for (int b = 0; b < ((sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4); b++) ref_mem[int'(a) + b] = wd[8 * b +: 8];
      end
      run_op(we, sz, uns, a, wd, rd, mis, lat, wc, wcy, wdat, rl);
      total++; if (rd !== exp_rd || mis !== exp_mis) begin bad++; $display("FAIL rnd%0d_rsp: got %h/%b want %h/%b (we %b sz %0d addr %h)", n, rd, mis, exp_rd, exp_mis, we, sz, a); end
      total++; if (lat != exp_lat || wc != exp_wc) begin bad++; $display("FAIL rnd%0d_timing: got lat %0d writes %0d want %0d %0d", n, lat, wc, exp_lat, exp_wc); end
    end
    for (int i = 0; i < 64; i++) begin
      w = {ref_mem[4 * i + 3], ref_mem[4 * i + 2], ref_mem[4 * i + 1], ref_mem[4 * i]};
      total++; if (mem[i] !== w) begin bad++; $display("FAIL rnd_mem%0d: got %h want %h", i, mem[i], w); end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    test_reset();
    test_loads();
    test_back_to_back();
    test_store_byte();
    test_store_word();
    test_misaligned();
    test_reset_rmw();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
